// File: rtl/fp16_pkg.sv
// Shared FP16 definitions for the TTPU arithmetic units.
// Field layout, special constants, classifiers and divider states.
package fp16_pkg;

  localparam int EXP_W    = 5;
  localparam int FRAC_W   = 10;
  localparam int EXP_BIAS = 15;
  localparam int EXP_MAX  = 31;

  localparam logic [15:0] FP16_QNAN = 16'h7E00;
  localparam logic [15:0] FP16_INF  = 16'h7C00;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    NORM,
    DONE
  } div_state_e;

  // Exponent field 0 is treated as zero: subnormals flush.
  function automatic logic is_zero(input logic [15:0] x);
    return x[14:10] == 5'd0;
  endfunction

  function automatic logic is_inf(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] == 10'd0);
  endfunction

  function automatic logic is_nan(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
  endfunction

endpackage

// File: rtl/fp16_special_case.sv
// Classifies divider operands that bypass the iterative path.
// Produces the final result word for NaN, zero and infinity cases.
module fp16_special_case
  import fp16_pkg::*;
(
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic        is_special_o,
  output logic [15:0] result_o
);

  logic sign;

  assign sign = a_i[15] ^ b_i[15];

  always_comb begin
    is_special_o = 1'b1;
    result_o     = 16'h0000;
    if (is_nan(a_i) || is_nan(b_i)) begin
      result_o = FP16_QNAN;
    end else if ((is_zero(a_i) && is_zero(b_i)) ||
                 (is_inf(a_i) && is_inf(b_i))) begin
      result_o = FP16_QNAN;
    end else if (is_zero(a_i) || is_inf(b_i)) begin
      result_o = {sign, 15'h0000};
    end else if (is_zero(b_i) || is_inf(a_i)) begin
      result_o = {sign, FP16_INF[14:0]};
    end else begin
      is_special_o = 1'b0;
    end
  end

endmodule

// File: rtl/fp16_divider.sv
// Iterative FP16 divider: restoring division, one quotient bit per
// cycle, truncation rounding, subnormals flushed to zero.
module fp16_divider
  import fp16_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ITER       = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  busy
);

  div_state_e state_q, state_d;

  logic        sign_q;
  logic [4:0]  ea_q, eb_q;
  logic [10:0] mb_q;
  logic [11:0] rem_q;
  logic [11:0] q_q;
  logic [3:0]  cnt_q;
  logic [15:0] res_q;

  logic        spec;
  logic [15:0] spec_res;

  fp16_special_case u_special (
    .a_i          (a),
    .b_i          (b),
    .is_special_o (spec),
    .result_o     (spec_res)
  );

  logic        rem_ge;
  logic [10:0] rem_sub;
  logic [11:0] rem_nx;

  // The true difference is below mb, so 11 bits hold it exactly.
  assign rem_ge  = rem_q >= {1'b0, mb_q};
  assign rem_sub = rem_q[10:0] - mb_q;
  assign rem_nx  = rem_ge ? {rem_sub, 1'b0}
                          : {rem_q[10:0], 1'b0};

  logic signed [6:0] e_raw, e_adj;
  logic [9:0]        frac;
  logic [15:0]       norm_res;

  always_comb begin
    e_raw = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q})
          + 7'sd15;
    e_adj = q_q[11] ? e_raw : e_raw - 7'sd1;
    frac  = q_q[11] ? q_q[10:1] : q_q[9:0];
    if (e_adj >= 7'sd31) begin
      norm_res = {sign_q, FP16_INF[14:0]};
    end else if (e_adj <= 7'sd0) begin
      norm_res = {sign_q, 15'h0000};
    end else begin
      norm_res = {sign_q, e_adj[4:0], frac};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (in_valid) state_d = spec ? DONE : DIVIDE;
      DIVIDE: if (cnt_q == 4'(ITER - 1)) state_d = NORM;
      NORM:   state_d = DONE;
      DONE:   if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = state_q == IDLE;
    out_valid = state_q == DONE;
    busy      = state_q != IDLE;
    result    = res_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sign_q <= 1'b0;
      ea_q   <= '0;
      eb_q   <= '0;
      mb_q   <= '0;
      rem_q  <= '0;
      q_q    <= '0;
      cnt_q  <= '0;
      res_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q <= a[15] ^ b[15];
            ea_q   <= a[14:10];
            eb_q   <= b[14:10];
            mb_q   <= {1'b1, b[9:0]};
            rem_q  <= {2'b01, a[9:0]};
            q_q    <= '0;
            cnt_q  <= '0;
            if (spec) res_q <= spec_res;
          end
        end
        DIVIDE: begin
          rem_q <= rem_nx;
          q_q   <= {q_q[10:0], rem_ge};
          cnt_q <= cnt_q + 4'd1;
        end
        NORM: res_q <= norm_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_divider.sv
// Randomised scoreboard bench for fp16_divider against an
// arithmetic reference model of FP16 truncating division.
module tb_fp16_divider;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        in_ready, out_valid, busy;
  logic [15:0] result;

  fp16_divider dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] res;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, req, cyc);
    end
  endtask

  // Quotient value is (ma/mb) * 2^(ea-eb); ma/mb lies in (0.5, 2).
  function automatic void ref_div(input logic [15:0] x,
                                  input logic [15:0] y,
                                  output logic [15:0] r,
                                  output int lat);
    logic s;
    int ex, ey, fx, fy, q, e;
    bit xn, yn, xi, yi, xz, yz;
    s  = x[15] ^ y[15];
    ex = int'(x[14:10]);
    ey = int'(y[14:10]);
    fx = int'(x[9:0]);
    fy = int'(y[9:0]);
    xn = (ex == 31) && (fx != 0);
    yn = (ey == 31) && (fy != 0);
    xi = (ex == 31) && (fx == 0);
    yi = (ey == 31) && (fy == 0);
    xz = ex == 0;
    yz = ey == 0;
    lat = 1;
    if (xn || yn) r = 16'h7E00;
    else if ((xz && yz) || (xi && yi)) r = 16'h7E00;
    else if (xz || yi) r = {s, 15'h0000};
    else if (yz || xi) r = {s, 15'h7C00};
    else begin
      lat = 14;
      q = ((1024 + fx) * 2048) / (1024 + fy);
      e = ex - ey + 14;
      while (q >= 2048) begin
        q = q / 2;
        e = e + 1;
      end
      if (e >= 31) r = {s, 15'h7C00};
      else if (e <= 0) r = {s, 15'h0000};
      else r = {s, e[4:0], q[9:0]};
    end
  endfunction

  logic        seen = 1'b0;
  logic [15:0] held = '0;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (sb.size() > 0)
        check("busy_state", {30'd0, in_ready, busy}, 32'd1);
      if (out_valid) begin
        if (!seen) begin
          if (sb.size() == 0) begin
            check("spurious_out", 32'd1, 32'd0);
          end else begin
            e = sb[0];
            check("result", {16'd0, result}, {16'd0, e.res});
            check("latency", cyc - e.acc + 1, e.lat);
          end
          held = result;
          seen = 1'b1;
        end else begin
          check("hold", {16'd0, result}, {16'd0, held});
        end
        if (out_ready) begin
          seen = 1'b0;
          if (sb.size() > 0) void'(sb.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        ref_div(a, b, e.res, e.lat);
        e.acc = cyc + 1;
        sb.push_back(e);
      end
    end
  end

  task automatic run_op(input logic [15:0] aa,
                        input logic [15:0] bb,
                        input bit rnd_ready);
    int k;
    @(posedge clk);
    #1;
    a = aa;
    b = bb;
    in_valid = 1'b1;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (k == 50) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int t = 0; t < 300 && sb.size() > 0; t++) begin
      if (rnd_ready) out_ready = 1'($urandom % 2);
      @(posedge clk);
      #1;
    end
    if (sb.size() > 0) begin
      check("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
    out_ready = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [15:0] dir_a[8] = '{16'h4200, 16'h3C00, 16'hC000, 16'h4000,
                            16'h0000, 16'h8000, 16'h7C00, 16'h7BFF};
  logic [15:0] dir_b[8] = '{16'h3E00, 16'h4200, 16'h4000, 16'h0000,
                            16'h0000, 16'h3C00, 16'h7C00, 16'h0400};

  initial begin
    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_result", {16'd0, result}, 32'd0);
    reset = 1'b1;
    out_ready = 1'b1;

    for (int i = 0; i < 8; i++) run_op(dir_a[i], dir_b[i], 1'b0);
    run_op(16'h0400, 16'h7BFF, 1'b0);

    // Back-pressure: result must hold and inputs be ignored.
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    a = 16'h4200;
    b = 16'h3E00;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    begin
      int k;
      for (k = 0; k < 40; k++) begin
        @(negedge clk);
        if (out_valid) break;
      end
      if (k == 40) check("bp_timeout", 32'd0, 32'd1);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'($urandom % 2);
      a = 16'($urandom);
      b = 16'($urandom);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_in_ready", {31'd0, in_ready}, 32'd1);
    check("bp_drained", sb.size(), 32'd0);
    sb.delete();

    // Reset mid-division abandons the operation.
    @(posedge clk);
    #1;
    a = 16'h4200;
    b = 16'h3E00;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("mid_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_result", {16'd0, result}, 32'd0);
    sb.delete();
    seen = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    run_op(16'h4200, 16'h3E00, 1'b0);

    for (int i = 0; i < 150; i++) begin
      logic [15:0] ra, rb;
      if (i % 3 == 0) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
      end else begin
        ra = {1'($urandom), 5'(4 + $urandom % 24), 10'($urandom)};
        rb = {1'($urandom), 5'(4 + $urandom % 24), 10'($urandom)};
      end
      run_op(ra, rb, 1'b1);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
